// File: rtl/octave_decimator_if.sv
// Sample-in / decimated-set-out handshake bundle for octave_decimator.
interface octave_decimator_if #(
    parameter int N   = 16,
    parameter int OCT = 5
);
    logic signed [N-1:0]   inSample;
    logic                  inValid;
    logic                  inReady;
    logic [OCT*N-1:0]      octSamples;
    logic [OCT-1:0]        enableOctaves;
    logic                  sampleReady;
    logic                  writeSample;

    // Source/consumer side: ADC front end plus operation manager
    modport master (
        output inSample, inValid, writeSample,
        input  inReady, octSamples, enableOctaves, sampleReady
    );

    // Decimator side
    modport slave (
        input  inSample, inValid, writeSample,
        output inReady, octSamples, enableOctaves, sampleReady
    );
endinterface

// File: rtl/octave_decimator.sv
// Octave-band decimator: one octave per cycle, each octave averaging sample pairs
// from the octave below, then presents the updated set until acknowledged.
module octave_decimator #(
    parameter int N   = 16,
    parameter int OCT = 5
) (
    input  logic               clk,
    input  logic               rst,
    octave_decimator_if.slave  bus
);
    localparam int unsigned KW = (OCT > 1) ? $clog2(OCT) : 1;

    typedef enum logic [1:0] {IDLE, CASCADE, PRESENT} state_t;

    state_t                state_q, state_d;
    logic signed [N-1:0]   cur_q, cur_d;
    logic [KW-1:0]         k_q, k_d;
    logic signed [N-1:0]   hold_q [OCT];
    logic signed [N-1:0]   hold_d [OCT];
    logic [OCT-1:0]        phase_q, phase_d;
    logic [OCT*N-1:0]      oct_q, oct_d;
    logic [OCT-1:0]        en_q, en_d;
    logic                  rdy_q, rdy_d;

    // Floor average on an (N+1)-bit sum, so the result always fits in N bits
    function automatic logic signed [N-1:0] avg(input logic signed [N-1:0] a,
                                                 input logic signed [N-1:0] b);
        logic signed [N:0] sum;
        sum = {a[N-1], a} + {b[N-1], b};
        return sum[N:1];
    endfunction

    // Next-state and datapath
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        k_d     = k_q;
        hold_d  = hold_q;
        phase_d = phase_q;
        oct_d   = oct_q;
        en_d    = en_q;
        rdy_d   = rdy_q;
        case (state_q)
            IDLE: begin
                if (bus.inValid) begin
                    cur_d   = bus.inSample;
                    k_d     = '0;
                    en_d    = '0;
                    state_d = CASCADE;
                end
            end
            CASCADE: begin
                oct_d[int'(k_q)*N +: N] = cur_q;
                en_d[k_q]               = 1'b1;
                if (k_q == KW'(OCT - 1)) begin
                    state_d = PRESENT;
                    rdy_d   = 1'b1;
                end else if (!phase_q[k_q]) begin
                    // First of a pair: park it and stop climbing
                    hold_d[k_q]  = cur_q;
                    phase_d[k_q] = 1'b1;
                    state_d      = PRESENT;
                    rdy_d        = 1'b1;
                end else begin
                    cur_d        = avg(hold_q[k_q], cur_q);
                    phase_d[k_q] = 1'b0;
                    k_d          = k_q + KW'(1);
                end
            end
            PRESENT: begin
                if (bus.writeSample) begin
                    rdy_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cur_q   <= '0;
            k_q     <= '0;
            hold_q  <= '{default: '0};
            phase_q <= '0;
            oct_q   <= '0;
            en_q    <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            k_q     <= k_d;
            hold_q  <= hold_d;
            phase_q <= phase_d;
            oct_q   <= oct_d;
            en_q    <= en_d;
            rdy_q   <= rdy_d;
        end
    end

    assign bus.inReady       = (state_q == IDLE);
    assign bus.octSamples    = oct_q;
    assign bus.enableOctaves = en_q;
    assign bus.sampleReady   = rdy_q;

endmodule

// File: tb/tb_octave_decimator.sv
// Randomized and directed checks of octave_decimator against a pairwise-average
// reference computed from the full input history.
module tb_octave_decimator;
    localparam int N   = 16;
    localparam int OCT = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    octave_decimator_if #(.N(N), .OCT(OCT)) bus ();
    octave_decimator #(.N(N), .OCT(OCT)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_pass   = 0;

    int             hist[$];
    int             exp_oct[OCT];
    logic [OCT-1:0] exp_en;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int ref_avg(input int a, input int b);
        int s;
        s = a + b;
        return s >>> 1;
    endfunction

    // Octave k value = k levels of pairwise floor averages over the last 2^k inputs
    function automatic int ref_octave(input int k);
        int w[16];
        int cnt;
        int base;
        cnt  = 1 << k;
        base = hist.size() - cnt;
        for (int j = 0; j < cnt; j++) w[j] = hist[base + j];
        for (int l = 0; l < k; l++) begin
            cnt = cnt / 2;
            for (int m = 0; m < cnt; m++) w[m] = ref_avg(w[2*m], w[2*m+1]);
        end
        return w[0];
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < OCT; k++) exp_oct[k] = 0;
        exp_en = '0;
    endtask

    task automatic model_push(input int v, output int s);
        int i;
        hist.push_back(v);
        i = hist.size() - 1;
        exp_en = '0;
        s = 0;
        for (int k = 0; k < OCT; k++) begin
            if (((i + 1) % (1 << k)) == 0) begin
                exp_en[k]  = 1'b1;
                exp_oct[k] = ref_octave(k);
                s++;
            end
        end
    endtask

    task automatic check_set(input string tag);
        logic [N-1:0] e;
        for (int k = 0; k < OCT; k++) begin
            e = N'(exp_oct[k]);
            check($sformatf("%s_oct%0d", tag, k), 32'(bus.octSamples[k*N +: N]), 32'(e));
        end
        check({tag, "_en"}, 32'(bus.enableOctaves), 32'(exp_en));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_oct"}, 32'(bus.octSamples == '0), 32'd1);
        check({tag, "_en"}, 32'(bus.enableOctaves), 32'd0);
        check({tag, "_srdy"}, 32'(bus.sampleReady), 32'd0);
        check({tag, "_irdy"}, 32'(bus.inReady), 32'd1);
    endtask

    task automatic apply_reset();
        bus.inValid = 1'b0;
        bus.writeSample = 1'b0;
        rst = 1'b0;
        #1;
        check_reset_vals("rst_low");
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check_reset_vals("rst_hold");
        end
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!bus.inReady && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("in_ready_idle", 32'(bus.inReady), 32'd1);
    endtask

    // One full transaction; hold_valid keeps inValid asserted while busy
    task automatic send(input int v, input bit hold_valid, input int stall);
        int s;
        int lat;
        wait_ready();
        model_push(v, s);
        bus.inSample = N'(v);
        bus.inValid  = 1'b1;
        @(posedge clk); #1;
        if (hold_valid) bus.inSample = N'($urandom);
        else bus.inValid = 1'b0;
        check("busy_in_ready", 32'(bus.inReady), 32'd0);
        lat = 0;
        while (!bus.sampleReady && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(s));
        check("present_in_ready", 32'(bus.inReady), 32'd0);
        check_set("set");
        for (int c = 0; c < stall; c++) begin
            @(posedge clk); #1;
            check("stall_srdy", 32'(bus.sampleReady), 32'd1);
            check_set("stall");
        end
        bus.writeSample = 1'b1;
        @(posedge clk); #1;
        bus.writeSample = 1'b0;
        bus.inValid = 1'b0;
        check("ack_srdy", 32'(bus.sampleReady), 32'd0);
        check("ack_in_ready", 32'(bus.inReady), 32'd1);
        check("idle_en", 32'(bus.enableOctaves), 32'(exp_en));
    endtask

    initial begin
        int s;
        bus.inSample = '0;
        bus.inValid = 1'b0;
        bus.writeSample = 1'b0;
        rst = 1'b1;
        #2;
        apply_reset();

        // Stray acknowledge while idle has no effect
        bus.writeSample = 1'b1;
        @(posedge clk); #1;
        bus.writeSample = 1'b0;
        check_reset_vals("stray_ack");

        send(100, 1'b0, 5);
        send(200, 1'b0, 1);

        apply_reset();
        send(-3, 1'b0, 0);
        send(-2, 1'b0, 0);

        apply_reset();
        send(32767, 1'b0, 0);
        send(32767, 1'b1, 0);

        apply_reset();
        send(-32768, 1'b0, 0);
        send(-32768, 1'b0, 0);

        apply_reset();
        for (int j = 0; j < 17; j++) send(1000, 1'b0, 0);

        // Reset in the middle of the 4th sample's cascade
        apply_reset();
        for (int j = 0; j < 3; j++) send(int'($urandom_range(0, 65535)) - 32768, 1'b0, 0);
        wait_ready();
        model_push(7, s);
        bus.inSample = N'(7);
        bus.inValid = 1'b1;
        @(posedge clk); #1;
        bus.inValid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check_reset_vals("mid_rst");
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        send(50, 1'b0, 0);

        apply_reset();
        for (int j = 0; j < 40; j++)
            send(int'($urandom_range(0, 65535)) - 32768, 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 3)));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/octave_decimator.md
OCTAVE_DECIMATOR -- requirements
Module: octave_decimator

Interface
REQ-001 SHALL have parameter N, default 16, giving the signed sample width.
REQ-002 SHALL have parameter OCT, default 5, giving the number of octaves fed downstream.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port inSample, input, N bits: signed audio sample from the ADC front end.
REQ-006 SHALL have port inValid, input, 1 bit: inSample is valid this cycle.
REQ-007 SHALL have port inReady, output, 1 bit: the block can accept a sample this cycle.
REQ-008 SHALL have port octSamples, output, OCT*N bits: newest signed sample per octave; octave k occupies bits [k*N +: N].
REQ-009 SHALL have port enableOctaves, output, OCT bits: bit k set means octave k holds a new sample for the current set.
REQ-010 SHALL have port sampleReady, output, 1 bit: a decimated sample set is presented to the operation manager.
REQ-011 SHALL have port writeSample, input, 1 bit: the operation manager has consumed the presented set.

Function
REQ-012 SHALL implement a three-state FSM with states IDLE, CASCADE and PRESENT.
REQ-013 inReady SHALL equal (state == IDLE), combinationally.
REQ-014 An accept SHALL occur on a rising edge with inValid and inReady both high. On accept the block SHALL:
- set cur to inSample;
- set octave index k to 0;
- clear enableOctaves;
- enter CASCADE.
REQ-015 inValid while not in IDLE SHALL be ignored; the block SHALL NOT buffer the sample and SHALL NOT change state.
REQ-016 Each CASCADE cycle SHALL process exactly one octave k, performing all of the following:
- write cur to octSamples[k];
- set enableOctaves[k].
REQ-017 In a CASCADE step with k == OCT-1, the block SHALL enter PRESENT.
REQ-018 In a CASCADE step with k < OCT-1 and phase[k] == 0, the block SHALL:
- store cur in hold[k];
- set phase[k] to 1;
- enter PRESENT.
REQ-019 In a CASCADE step with k < OCT-1 and phase[k] == 1, the block SHALL:
- set cur to avg(hold[k], cur);
- clear phase[k];
- increment k;
- remain in CASCADE.
REQ-020 avg SHALL compute the (N+1)-bit signed sum of its two operands, arithmetic-shift it right by 1 (floor), and truncate the result to N bits; overflow SHALL therefore never occur.
REQ-021 Octave k SHALL update on input index i (0-based since reset) exactly when (i+1) is divisible by 2^k, for k < OCT.
REQ-022 With s updated octaves, sampleReady SHALL first be high in the cycle after the s-th rising edge following the accept edge (latency s cycles, 1 <= s <= OCT).
REQ-023 In PRESENT, sampleReady SHALL be held high and octSamples/enableOctaves held stable until writeSample is sampled high; the block SHALL then enter IDLE.
REQ-024 writeSample outside PRESENT SHALL be ignored.
REQ-025 octSamples entries of octaves not updated in the current set SHALL retain their previous values.
REQ-026 enableOctaves SHALL remain valid through IDLE until the next accept.

Reset
REQ-027 On rst low, asynchronously, the block SHALL:
- force state to IDLE;
- clear octSamples, enableOctaves, hold[] and phase[];
- clear cur and k;
- deassert sampleReady;
- assert inReady.
REQ-028 Reset mid-CASCADE or mid-PRESENT SHALL discard the partial set; the next accepted sample SHALL behave as input index 0.

Verification
REQ-029 Reset check: rst low -> octSamples=0, enableOctaves=00000, sampleReady=0, inReady=1; these values SHALL hold for 3 cycles after release.
REQ-030 First sample: accept 100 -> sampleReady high 1 cycle later, enableOctaves=00001, octave0=100, inReady=0. Holding writeSample low 5 cycles -> outputs stable. writeSample pulse -> inReady=1 next cycle.
REQ-031 Pairing: accept 100 then 200 (each acknowledged) -> second set enableOctaves=00011, octave1=150, latency 2 cycles.
REQ-032 Rounding and saturation-free sum:
- -3 then -2 -> octave1=-3 (floor of -2.5);
- 32767 then 32767 -> octave1=32767;
- -32768 then -32768 -> octave1=-32768.
REQ-033 Full cascade: 16 acknowledged samples of constant 1000 ->
- 16th set enableOctaves=11111, all octaves=1000, latency 5 cycles;
- 8th set enableOctaves=01111;
- 17th set enableOctaves=00001.
REQ-034 Backpressure and reset:
- inValid high during CASCADE/PRESENT -> no accept, no state change;
- rst low during CASCADE of the 4th sample -> all cleared; next sample 50 -> enableOctaves=00001, octave0=50, octave1=0.
